// File: rtl/mips_prog_loader.sv
// Byte-stream instruction image loader: frames a length-prefixed, checksummed
// image into big-endian words and writes them to instruction memory from address 0.
module mips_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    // Holds the first three bytes of the word in flight; the 4th comes straight from in_data.
    logic [23:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [15:0]       len_rx;
    logic              take;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state (low while rst_n is asserted), never on in_valid.
    always_comb begin
        in_ready = rst_n && ((state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                             (state_q == S_DATA)   || (state_q == S_CHECK));
    end

    assign take   = in_valid && in_ready;
    assign len_rx = {len_q[15:8], in_data};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        if (start) begin
            // Start wins over a byte in the same cycle and cancels any pending write.
            state_d     = S_LEN_HI;
            word_cnt_d  = 16'd0;
            byte_cnt_d  = 2'd0;
            csum_d      = 8'd0;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            cpu_hold_d  = 1'b1;
        end else if (take) begin
            case (state_q)
                S_LEN_HI: begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = len_rx;
                    if ({1'b0, len_rx} > DEPTH_W) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    asm_d      = {asm_q[15:0], in_data};
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {asm_q, in_data};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (in_data == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            byte_cnt_q  <= 2'd0;
            csum_q      <= 8'd0;
            asm_q       <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frames with known checksums, error frames,
// start/reset interruption, and a write scoreboard keyed on address and data.
module tb_mips_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;
    bit gap_en = 1'b0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        prog[9];

    mips_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every write is matched against the scoreboard; writes nobody expected are flagged.
    always @(posedge clk1) begin
        #1;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(mem_we), 32'd0);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk1);
                in_valid = 1'b0;
            end
        end
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk1);
    endtask

    task automatic idle(input int n);
        @(negedge clk1);
        in_valid = 1'b0;
        repeat (n) @(negedge clk1);
    endtask

    task automatic send_word(input int addr, input logic [31:0] w);
        exp_q.push_back({ADDR_W'(addr), w});
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
        #2;
        check("we_timing", 32'(mem_we), 32'd1);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic rdy);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"},  32'(load_err),  32'(err));
        check({tag, "_hold"}, 32'(cpu_hold),  32'(hold));
        check({tag, "_rdy"},  32'(in_ready),  32'(rdy));
    endtask

    task automatic pulse_start();
        @(negedge clk1);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check_status("after_start", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_prog(input logic [7:0] csum);
        send_byte(8'h00);
        send_byte(8'h09);
        for (int k = 0; k < 9; k++) send_word(k, prog[k]);
        send_byte(csum);
        #2;
    endtask

    task automatic send_two_word();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(0, 32'h0000_0001);
        send_word(1, 32'h0000_0002);
        send_byte(8'h03);
        #2;
        check_status("two_word", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

        // Reset state
        repeat (2) @(posedge clk1);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        check_status("post_rst", 1'b0, 1'b0, 1'b1, 1'b1);

        // Good 9-word image, in_valid held high
        send_prog(8'hDF);
        check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_status("good_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bad checksum: all writes still happen
        pulse_start();
        send_prog(8'hDE);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);

        // N = 1025 exceeds DEPTH
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        #2;
        check_status("too_long", 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Empty image, good and bad checksum
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        #2;
        check_status("empty_ok", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        #2;
        check_status("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);

        // Abort after 6 payload bytes (word 0 written)
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(0, 32'h0000_00aa);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();

        // Start with a valid 4th byte: no write, byte not consumed (0x05 as N_hi would force ERR)
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;
        @(posedge clk1);
        #2;
        check("start_we_suppressed", 32'(mem_we), 32'd0);
        @(negedge clk1);
        start    = 1'b0;
        in_valid = 1'b0;
        send_two_word();

        // Random in_valid gaps on the 9-word image
        pulse_start();
        gap_en = 1'b1;
        send_prog(8'hDF);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-DATA discards the frame
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h09);
        for (int k = 0; k < 3; k++) send_word(k, prog[k]);
        send_byte(8'h0c);
        send_byte(8'he7);
        gap_en = 1'b0;
        @(negedge clk1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h78;
        @(posedge clk1);
        #2;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(8);
        check_status("post_midrst", 1'b0, 1'b0, 1'b1, 1'b1);
        check("post_midrst_we", 32'(mem_we), 32'd0);
        send_two_word();

        idle(3);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Byte-stream program loader upstream of pipe_MIPS32.
- Receives a framed instruction image over a valid/ready byte interface, assembles big-endian 32-bit words, and writes them sequentially into processor instruction memory from address 0.
- Verifies an 8-bit additive checksum.
- Holds the processor (cpu_hold) until a good image is fully loaded, replacing backdoor Mem[] initialisation in benches.

Parameters:
- ADDR_W, 10, instruction memory address width in words.
- DEPTH, 1024, maximum loadable words; must be ≤ 2**ADDR_W.

Ports:
- clk1  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; aborts any load and restarts framing.
- in_valid  in  1  byte available.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts byte this cycle.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_addr  out  ADDR_W  word address for write.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  keep processor halted / PC at 0.
- load_done  out  1  image loaded, checksum good (level).
- load_err  out  1  length or checksum error (level).

Behaviour:
- Reset (rst_n=0 at edge):
  - State LEN_HI.
  - in_ready=0 on the reset cycle, 1 the cycle after.
  - mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
  - Word counter, byte counter and checksum cleared.
  - Reset mid-load discards everything; no further writes.
- Byte transfer: a byte is taken at an edge where in_valid && in_ready. in_ready is combinationally 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in DONE and ERR.
- Frame format:
  - 16-bit word count N, MSB byte first.
  - Then 4*N payload bytes, each word MSB byte first.
  - Then 1 checksum byte = sum of all payload bytes mod 256. Length bytes are excluded.
- States:
  - LEN_HI: take N[15:8] → LEN_LO.
  - LEN_LO: take N[7:0].
    - If N > DEPTH → ERR.
    - Else if N == 0 → CHECK.
    - Else → DATA.
  - DATA:
    - Shift bytes into a 32-bit assembly register and add each byte to the checksum.
    - On the 4th byte of word k: at the next edge, mem_we=1, mem_addr=k, mem_wdata=assembled word (registered, single-cycle pulse).
    - After word N-1 → CHECK.
    - Back-to-back words give one write every 4 accepted bytes; in_valid gaps only stretch timing.
  - CHECK: take one byte.
    - If equal to the running sum → DONE: load_done=1 and cpu_hold=0 from the edge after acceptance.
    - Else → ERR: load_err=1 and cpu_hold stays 1.
  - DONE / ERR: hold outputs until start or reset.
- start:
  - Valid in any state and has priority over byte acceptance in the same cycle; the byte is not consumed.
  - Returns to LEN_HI; clears counters, checksum, load_done and load_err; sets cpu_hold=1.
  - A mem_we already scheduled for that edge is suppressed.
  - Already-written memory words are not erased.
- Widths:
  - Checksum wraps mod 256.
  - Word counter is 16 bits; mem_addr is the low ADDR_W bits (always < DEPTH given the N check).
- mem_we never asserts outside DATA-generated writes. Exactly N write pulses occur per successful frame.

Test Plan:
- Reset, then stream 00 09, the nine words 2801000a 28020014 28030019 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000, then checksum DF, with in_valid held high → nine mem_we pulses, addr 0..8 with matching wdata, each on the edge after the 4th byte; load_done=1, cpu_hold=0, load_err=0.
- Same frame with checksum DE → all nine writes occur; load_err=1, load_done=0, cpu_hold stays 1, in_ready=0.
- Frame 04 01 (N=1025 > DEPTH) → ERR right after the second byte; no mem_we; load_err=1.
- Frame 00 00 00 → load_done=1 with zero writes; frame 00 00 05 → load_err=1.
- Start pulse after 6 payload bytes (word 0 written), then a full 2-word frame 00 02 00000001 00000002 03 → writes addr 0=1, 1=2; load_done=1. Also assert start together with a valid byte: the byte is not consumed.
- Random in_valid gaps on the first frame, plus rst_n=0 mid-DATA → identical writes with gaps; after reset, no writes and all outputs at reset values.
